// File: rtl/game_pkg.sv
// Shared types and constants for the Pac-Man game-state controller.
package game_pkg;

   typedef enum logic [2:0] {
      ST_RESTART   = 3'd0,
      ST_PAUSE     = 3'd1,
      ST_RUN       = 3'd2,
      ST_FREEZE    = 3'd3,
      ST_GAME_OVER = 3'd4,
      ST_GAME_WON  = 3'd5
   } state_t;

   localparam logic [7:0] KEY_ESC   = 8'h29;
   localparam logic [7:0] KEY_SPACE = 8'h2C;
   localparam logic [7:0] KEY_P     = 8'h13;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_W     = 8'h1A;

   localparam int DEF_COORD_W = 10;

   // Movement keys that also release the game from PAUSE.
   function automatic logic is_move_key(input logic [7:0] key);
      return (key == KEY_A) || (key == KEY_D) || (key == KEY_S) || (key == KEY_W);
   endfunction

endpackage

// File: rtl/box_hit.sv
// Centre/half-extent overlap test between two square sprites, with a
// forgiven overlap margin. Purely combinational.
module box_hit
   import game_pkg::*;
#(
   parameter int COORD_W = DEF_COORD_W,
   parameter int MARGIN  = 2
) (
   input  logic [COORD_W-1:0] ax,
   input  logic [COORD_W-1:0] ay,
   input  logic [COORD_W-1:0] asize,
   input  logic [COORD_W-1:0] bx,
   input  logic [COORD_W-1:0] by,
   input  logic [COORD_W-1:0] bsize,
   output logic               hit
);

   logic [COORD_W:0]          dx;
   logic [COORD_W:0]          dy;
   logic signed [COORD_W+1:0] thr_raw;
   logic [COORD_W:0]          thr;

   // Both axis distances must be below the combined half-extents less the
   // margin; a negative threshold clamps to zero so nothing can hit.
   always_comb begin
      dx      = (ax >= bx) ? ({1'b0, ax} - {1'b0, bx}) : ({1'b0, bx} - {1'b0, ax});
      dy      = (ay >= by) ? ({1'b0, ay} - {1'b0, by}) : ({1'b0, by} - {1'b0, ay});
      thr_raw = $signed({2'b00, asize}) + $signed({2'b00, bsize})
                - $signed((COORD_W+2)'(MARGIN));
      thr     = (thr_raw < 0) ? '0 : thr_raw[COORD_W:0];
      hit     = (dx < thr) && (dy < thr);
   end

endmodule

// File: rtl/game_state_ctrl.sv
// Top-level game-state controller: ghost/fruit hit detection once per frame,
// score / fruit mask / lives ownership, freeze window and pause toggle.
// Optional macro GAME_STATE_CTRL_COMBO_EN: a fruit eaten within 120 frames of
// the previous one scores double points.
module game_state_ctrl
   import game_pkg::*;
#(
   parameter int NUM_GHOSTS    = 4,
   parameter int NUM_FRUITS    = 4,
   parameter int COORD_W       = DEF_COORD_W,
   parameter int SCORE_W       = 12,
   parameter int MAX_LIVES     = 3,
   parameter int FRUIT_POINTS  = 50,
   parameter int FRUIT_BOX     = 26,
   parameter int FREEZE_FRAMES = 60,
   parameter int HIT_MARGIN    = 2
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         frame_tick,
   input  logic [7:0]                   keycode,
   input  logic                         time_up,
   input  logic [COORD_W-1:0]           pX,
   input  logic [COORD_W-1:0]           pY,
   input  logic [COORD_W-1:0]           pSize,
   input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_x,
   input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_y,
   input  logic [COORD_W-1:0]           gSize,
   input  logic [NUM_FRUITS*COORD_W-1:0] fruit_x,
   input  logic [NUM_FRUITS*COORD_W-1:0] fruit_y,
   output logic [2:0]                   state_o,
   output logic [SCORE_W-1:0]           score,
   output logic [NUM_FRUITS-1:0]        fruits_eaten,
   output logic [2:0]                   lives,
   output logic                         restart,
   output logic                         life_lost,
   output logic                         fruit_pulse,
   output logic                         frozen,
   output logic                         win,
   output logic                         lose
);

   localparam int               FRZ_W      = $clog2(FREEZE_FRAMES + 2);
   localparam logic [2:0]       LIVES_INIT = 3'(MAX_LIVES);
   localparam logic [SCORE_W:0] PTS_1X     = (SCORE_W+1)'(FRUIT_POINTS);
   localparam logic [SCORE_W+1:0] SCORE_MAX = (SCORE_W+2)'({SCORE_W{1'b1}});

   state_t                state, state_nxt;
   logic [7:0]            key_prev;
   logic                  press;
   logic [FRZ_W-1:0]      frz_cnt, frz_cnt_nxt;
   logic [SCORE_W-1:0]    score_nxt;
   logic [NUM_FRUITS-1:0] mask_nxt;
   logic [2:0]            lives_nxt;
   logic                  life_lost_nxt, fruit_pulse_nxt;
   logic [NUM_GHOSTS-1:0] ghost_hits;
   logic [NUM_FRUITS-1:0] fruit_hits, fruit_avail, fruit_sel;
   logic [SCORE_W:0]      fruit_pts;

   // Score addition that sticks at the all-ones value instead of wrapping.
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [SCORE_W:0]   b);
      logic [SCORE_W+1:0] s;
      s = {2'b00, a} + {1'b0, b};
      return (s > SCORE_MAX) ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
   endfunction

   assign press   = (keycode != key_prev) && (keycode != 8'h00);
   assign state_o = state;

   for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ghost
      box_hit #(.COORD_W(COORD_W), .MARGIN(HIT_MARGIN)) u_hit (
         .ax(pX), .ay(pY), .asize(pSize),
         .bx(ghost_x[g*COORD_W +: COORD_W]), .by(ghost_y[g*COORD_W +: COORD_W]),
         .bsize(gSize), .hit(ghost_hits[g])
      );
   end

   for (genvar f = 0; f < NUM_FRUITS; f++) begin : g_fruit
      logic [COORD_W:0] fx, fy;
      assign fx = {1'b0, fruit_x[f*COORD_W +: COORD_W]};
      assign fy = {1'b0, fruit_y[f*COORD_W +: COORD_W]};
      assign fruit_hits[f] = ({1'b0, pX} >= fx) && ({1'b0, pX} <= fx + (COORD_W+1)'(FRUIT_BOX-1)) &&
                             ({1'b0, pY} >= fy) && ({1'b0, pY} <= fy + (COORD_W+1)'(FRUIT_BOX-1));
   end

   // Lowest-index uneaten fruit under the player (isolate lowest set bit).
   assign fruit_avail = fruit_hits & ~fruits_eaten;
   assign fruit_sel   = fruit_avail & (~fruit_avail + NUM_FRUITS'(1));

`ifdef GAME_STATE_CTRL_COMBO_EN
   localparam int COMBO_WINDOW = 120;
   logic [6:0] combo_cnt;
   logic       combo_vld;

   // Count frames since the previous fruit; cleared by restart and ghost hits.
   always_ff @(posedge Clk) begin
      if (Reset || (state == ST_RESTART) || life_lost_nxt) begin
         combo_vld <= 1'b0;
         combo_cnt <= '0;
      end else if (fruit_pulse_nxt) begin
         combo_vld <= 1'b1;
         combo_cnt <= '0;
      end else if (frame_tick && (combo_cnt != 7'h7F)) begin
         combo_cnt <= combo_cnt + 7'd1;
      end
   end

   assign fruit_pts = (combo_vld && (combo_cnt < 7'(COMBO_WINDOW))) ? (PTS_1X << 1) : PTS_1X;
`else
   assign fruit_pts = PTS_1X;
`endif

   // Next-state and next-register logic; escape overrides every state.
   always_comb begin
      state_nxt       = state;
      frz_cnt_nxt     = frz_cnt;
      score_nxt       = score;
      mask_nxt        = fruits_eaten;
      lives_nxt       = lives;
      life_lost_nxt   = 1'b0;
      fruit_pulse_nxt = 1'b0;
      if (press && (keycode == KEY_ESC)) begin
         state_nxt = ST_RESTART;
      end else begin
         case (state)
            ST_RESTART: state_nxt = ST_PAUSE;
            ST_PAUSE: begin
               if (press && (is_move_key(keycode) || (keycode == KEY_P)))
                  state_nxt = ST_RUN;
            end
            ST_RUN: begin
               if (frame_tick) begin
                  if (time_up) begin
                     state_nxt = ST_GAME_OVER;
                  end else if (|ghost_hits) begin
                     lives_nxt     = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
                     life_lost_nxt = 1'b1;
                     if (lives <= 3'd1) begin
                        state_nxt = ST_GAME_OVER;
                     end else begin
                        state_nxt   = ST_FREEZE;
                        frz_cnt_nxt = FRZ_W'(FREEZE_FRAMES);
                     end
                  end else if (|fruit_sel) begin
                     mask_nxt        = fruits_eaten | fruit_sel;
                     score_nxt       = sat_add(score, fruit_pts);
                     fruit_pulse_nxt = 1'b1;
                     if (&mask_nxt) state_nxt = ST_GAME_WON;
                  end
               end
               if ((state_nxt == ST_RUN) && press && (keycode == KEY_P))
                  state_nxt = ST_PAUSE;
            end
            ST_FREEZE: begin
               if (frame_tick) begin
                  if (frz_cnt <= FRZ_W'(1)) begin
                     frz_cnt_nxt = '0;
                     state_nxt   = ST_RUN;
                  end else begin
                     frz_cnt_nxt = frz_cnt - FRZ_W'(1);
                  end
               end
            end
            ST_GAME_OVER, ST_GAME_WON: begin
               if (press && (keycode == KEY_SPACE)) state_nxt = ST_RESTART;
            end
            default: state_nxt = ST_RESTART;
         endcase
      end
      if (state_nxt == ST_RESTART) begin
         score_nxt   = '0;
         mask_nxt    = '0;
         lives_nxt   = LIVES_INIT;
         frz_cnt_nxt = '0;
      end
   end

   // Register state, game data and all status outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state        <= ST_RESTART;
         key_prev     <= 8'h00;
         frz_cnt      <= '0;
         score        <= '0;
         fruits_eaten <= '0;
         lives        <= LIVES_INIT;
         restart      <= 1'b0;
         life_lost    <= 1'b0;
         fruit_pulse  <= 1'b0;
         frozen       <= 1'b1;
         win          <= 1'b0;
         lose         <= 1'b0;
      end else begin
         state        <= state_nxt;
         key_prev     <= keycode;
         frz_cnt      <= frz_cnt_nxt;
         score        <= score_nxt;
         fruits_eaten <= mask_nxt;
         lives        <= lives_nxt;
         restart      <= (state_nxt == ST_RESTART);
         life_lost    <= life_lost_nxt;
         fruit_pulse  <= fruit_pulse_nxt;
         frozen       <= (state_nxt == ST_FREEZE) || (state_nxt == ST_PAUSE);
         win          <= (state_nxt == ST_GAME_WON);
         lose         <= (state_nxt == ST_GAME_OVER);
      end
   end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed scenarios with literal
// expectations, then randomized play checked every cycle against a
// behavioural model of the game rules.
module tb_game_state_ctrl;
   import game_pkg::*;

   localparam int NG = 4;
   localparam int NF = 4;
   localparam int CW = 10;

   logic           Clk = 1'b0;
   logic           Reset = 1'b1;
   logic           frame_tick = 1'b0;
   logic [7:0]     keycode = 8'h00;
   logic           time_up = 1'b0;
   logic [CW-1:0]  pX = '0, pY = '0, pSize = '0, gSize = '0;
   logic [NG*CW-1:0] ghost_x = '0, ghost_y = '0;
   logic [NF*CW-1:0] fruit_x = '0, fruit_y = '0;
   logic [2:0]     state_o;
   logic [11:0]    score;
   logic [NF-1:0]  fruits_eaten;
   logic [2:0]     lives;
   logic           restart, life_lost, fruit_pulse, frozen, win, lose;

   int checks = 0;
   int errors = 0;

   game_state_ctrl #(
      .NUM_GHOSTS(NG), .NUM_FRUITS(NF), .COORD_W(CW), .SCORE_W(12), .MAX_LIVES(3),
      .FRUIT_POINTS(50), .FRUIT_BOX(26), .FREEZE_FRAMES(60), .HIT_MARGIN(2)
   ) dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .keycode(keycode), .time_up(time_up),
      .pX(pX), .pY(pY), .pSize(pSize), .ghost_x(ghost_x), .ghost_y(ghost_y), .gSize(gSize),
      .fruit_x(fruit_x), .fruit_y(fruit_y), .state_o(state_o), .score(score),
      .fruits_eaten(fruits_eaten), .lives(lives), .restart(restart), .life_lost(life_lost),
      .fruit_pulse(fruit_pulse), .frozen(frozen), .win(win), .lose(lose)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit     m_vld = 0;
   state_t m_st;
   int     m_score, m_lives, m_frz, m_prev;
   bit [NF-1:0] m_mask;
   bit     m_restart, m_ll, m_fp, m_frozen, m_win, m_lose;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic bit any_ghost_hit();
      int thr;
      thr = int'(pSize) + int'(gSize) - 2;
      if (thr < 0) thr = 0;
      for (int i = 0; i < NG; i++) begin
         if (iabs(int'(pX) - int'(ghost_x[i*CW +: CW])) < thr &&
             iabs(int'(pY) - int'(ghost_y[i*CW +: CW])) < thr) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic int first_fruit();
      int fx, fy;
      for (int i = 0; i < NF; i++) begin
         fx = int'(fruit_x[i*CW +: CW]);
         fy = int'(fruit_y[i*CW +: CW]);
         if (!m_mask[i] && int'(pX) >= fx && int'(pX) < fx + 26 &&
             int'(pY) >= fy && int'(pY) < fy + 26) return i;
      end
      return -1;
   endfunction

   task automatic model_step();
      bit     pr;
      state_t ns;
      int     fi;
      if (Reset) begin
         m_st = ST_RESTART; m_score = 0; m_mask = '0; m_lives = 3; m_frz = 0; m_prev = 0;
         m_restart = 0; m_ll = 0; m_fp = 0; m_frozen = 1; m_win = 0; m_lose = 0;
         m_vld = 1;
         return;
      end
      pr = (int'(keycode) != m_prev) && (keycode != 8'h00);
      m_prev = int'(keycode);
      m_ll = 0; m_fp = 0;
      ns = m_st;
      fi = first_fruit();
      if (pr && keycode == 8'h29) ns = ST_RESTART;
      else if (m_st == ST_RESTART) ns = ST_PAUSE;
      else if (m_st == ST_PAUSE) begin
         if (pr && (keycode inside {8'h04, 8'h07, 8'h16, 8'h1A, 8'h13})) ns = ST_RUN;
      end else if (m_st == ST_RUN) begin
         if (frame_tick && time_up) ns = ST_GAME_OVER;
         else if (frame_tick && any_ghost_hit()) begin
            m_lives = m_lives - 1; m_ll = 1;
            if (m_lives == 0) ns = ST_GAME_OVER;
            else begin ns = ST_FREEZE; m_frz = 60; end
         end else if (frame_tick && fi >= 0) begin
            m_mask[fi] = 1'b1; m_fp = 1;
            m_score = (m_score + 50 > 4095) ? 4095 : m_score + 50;
            if (m_mask == '1) ns = ST_GAME_WON;
         end
         if (ns == ST_RUN && pr && keycode == 8'h13) ns = ST_PAUSE;
      end else if (m_st == ST_FREEZE) begin
         if (frame_tick) begin
            m_frz = m_frz - 1;
            if (m_frz == 0) ns = ST_RUN;
         end
      end else begin
         if (pr && keycode == 8'h2C) ns = ST_RESTART;
      end
      if (ns == ST_RESTART) begin
         m_score = 0; m_mask = '0; m_lives = 3; m_frz = 0;
      end
      m_st = ns;
      m_restart = (ns == ST_RESTART);
      m_frozen  = (ns == ST_FREEZE) || (ns == ST_PAUSE);
      m_win     = (ns == ST_GAME_WON);
      m_lose    = (ns == ST_GAME_OVER);
   endtask

   // Advance the model on every active edge (inputs change only after it).
   always @(posedge Clk) model_step();

   // Compare every output against the model away from the active edge.
   always @(negedge Clk) begin
      if (m_vld) begin
         chk("m_state", 32'(state_o), 32'(m_st));
         chk("m_score", 32'(score), 32'(m_score));
         chk("m_mask", 32'(fruits_eaten), 32'(m_mask));
         chk("m_lives", 32'(lives), 32'(m_lives));
         chk("m_restart", 32'(restart), 32'(m_restart));
         chk("m_life_lost", 32'(life_lost), 32'(m_ll));
         chk("m_fruit_pulse", 32'(fruit_pulse), 32'(m_fp));
         chk("m_frozen", 32'(frozen), 32'(m_frozen));
         chk("m_win", 32'(win), 32'(m_win));
         chk("m_lose", 32'(lose), 32'(m_lose));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic frame();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
   endtask

   task automatic key(input logic [7:0] k);
      keycode = k;
      cyc();
      keycode = 8'h00;
   endtask

   task automatic set_ghost(input int i, input int x, input int y);
      ghost_x[i*CW +: CW] = CW'(x);
      ghost_y[i*CW +: CW] = CW'(y);
   endtask

   task automatic set_fruit(input int i, input int x, input int y);
      fruit_x[i*CW +: CW] = CW'(x);
      fruit_y[i*CW +: CW] = CW'(y);
   endtask

   initial begin
      for (int i = 0; i < NG; i++) set_ghost(i, 700, 700);
      set_fruit(0, 12, 10);
      for (int i = 1; i < NF; i++) set_fruit(i, 900, 900);
      repeat (3) cyc();
      chk("rst_lives", 32'(lives), 3);
      chk("rst_score", 32'(score), 0);
      chk("rst_frozen", 32'(frozen), 1);
      chk("rst_restart", 32'(restart), 0);
      Reset = 1'b0;
      cyc();
      chk("pause_after_rst", 32'(state_o), 32'(ST_PAUSE));

      key(8'h29);
      chk("esc_restart_state", 32'(state_o), 32'(ST_RESTART));
      chk("esc_restart_pulse", 32'(restart), 1);
      cyc();
      chk("restart_pulse_end", 32'(restart), 0);
      key(8'h07);
      chk("run_state", 32'(state_o), 32'(ST_RUN));
      chk("run_lives", 32'(lives), 3);
      chk("run_frozen", 32'(frozen), 0);

      pX = 20; pY = 20; pSize = 8; gSize = 8;
      frame();
      chk("fruit0_mask", 32'(fruits_eaten), 1);
      chk("fruit0_score", 32'(score), 50);
      chk("fruit0_pulse", 32'(fruit_pulse), 1);
      cyc();
      chk("fruit0_pulse_end", 32'(fruit_pulse), 0);
      frame();
      chk("fruit0_no_rescore", 32'(score), 50);

      set_ghost(2, 34, 20);
      frame();
      chk("ghost_edge_nohit", 32'(lives), 3);
      set_ghost(2, 23, 20);
      frame();
      chk("ghost_hit_pulse", 32'(life_lost), 1);
      chk("ghost_hit_lives", 32'(lives), 2);
      chk("ghost_hit_freeze", 32'(state_o), 32'(ST_FREEZE));
      set_ghost(2, 700, 700);
      time_up = 1'b1;
      repeat (59) frame();
      chk("freeze_59", 32'(state_o), 32'(ST_FREEZE));
      time_up = 1'b0;
      frame();
      chk("freeze_60_run", 32'(state_o), 32'(ST_RUN));

      set_fruit(1, 15, 15);
      set_ghost(2, 23, 20);
      frame();
      chk("tie_lives", 32'(lives), 1);
      chk("tie_mask", 32'(fruits_eaten), 1);
      set_ghost(2, 700, 700);
      repeat (60) frame();
      chk("freeze2_run", 32'(state_o), 32'(ST_RUN));
      set_ghost(2, 23, 20);
      frame();
      chk("last_life_over", 32'(state_o), 32'(ST_GAME_OVER));
      chk("last_life_lose", 32'(lose), 1);
      chk("last_life_lives", 32'(lives), 0);
      set_ghost(2, 700, 700);

      key(8'h2C);
      chk("space_restart", 32'(restart), 1);
      chk("space_lives", 32'(lives), 3);
      cyc();
      keycode = 8'h13;
      repeat (10) cyc();
      chk("p_held_once", 32'(state_o), 32'(ST_RUN));
      keycode = 8'h00; cyc();
      key(8'h13);
      chk("p_to_pause", 32'(state_o), 32'(ST_PAUSE));
      cyc();
      key(8'h13);
      chk("p_to_run", 32'(state_o), 32'(ST_RUN));

      for (int i = 0; i < NF; i++) set_fruit(i, 100 * (i + 1), 100);
      pSize = 1; gSize = 0;
      set_ghost(0, 20, 20);
      frame();
      chk("neg_thr_nohit", 32'(lives), 3);
      pSize = 8; gSize = 8;
      set_ghost(0, 700, 700);

      for (int i = 0; i < NF; i++) begin
         pX = CW'(100 * (i + 1) + 5); pY = 105;
         frame();
         chk("eat_score", 32'(score), 32'(50 * (i + 1)));
      end
      chk("all_mask", 32'(fruits_eaten), 15);
      chk("all_win", 32'(win), 1);
      chk("all_state", 32'(state_o), 32'(ST_GAME_WON));
      key(8'h2C);
      chk("won_restart", 32'(state_o), 32'(ST_RESTART));
      cyc();
      key(8'h04);
      pX = 20; pY = 20;
      time_up = 1'b1;
      cyc();
      chk("timeup_no_tick", 32'(state_o), 32'(ST_RUN));
      frame();
      chk("timeup_over", 32'(lose), 1);
      time_up = 1'b0;

      // Randomized play.
      for (int i = 0; i < NF; i++) set_fruit(i, $urandom_range(0, 50), $urandom_range(0, 50));
      for (int n = 0; n < 5000; n++) begin
         Reset      = ($urandom_range(0, 999) == 0);
         frame_tick = ($urandom_range(0, 2) == 0);
         time_up    = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 15))
               0:       keycode = 8'h29;
               1, 2:    keycode = 8'h2C;
               3, 4:    keycode = 8'h13;
               5, 6:    keycode = 8'h04;
               7:       keycode = 8'h1A;
               8:       keycode = 8'h05;
               default: keycode = 8'h00;
            endcase
         end
         pX = CW'($urandom_range(0, 70));
         pY = CW'($urandom_range(0, 70));
         pSize = CW'($urandom_range(0, 10));
         gSize = CW'($urandom_range(0, 10));
         for (int g = 0; g < NG; g++) set_ghost(g, $urandom_range(0, 200), $urandom_range(0, 200));
         cyc();
      end
      Reset = 1'b0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
